exc_ctrl: RTL and testbench

//  MEM-stage exception controller driving cp0_reg's exception inputs. Gathers per-stage exception flags, applies

---
 rtl/exc_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_exc_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// exc_ctrl: MEM-stage exception controller feeding the CP0 exception inputs.
//  Collects per-stage exception flags plus pending interrupts, picks the
//  highest-priority cause, pulses one excepttype code to CP0 for one cycle,
//  flushes the pipeline for FLUSH_CYCLES, then holds a fetch redirect (handler
//  vector, or EPC on eret) until fetch accepts it. Also synchronises the
//  external interrupt lines for CP0.
// Ports:
//  clk, rst                      clock, synchronous active-high reset
//  int_i, timer_int_i            raw interrupt lines, CP0 timer interrupt
//  int_sync_o                    synchronised interrupts to CP0 int_i
//  mem_valid_i, mem_stall_i      MEM-stage instruction valid / stalled
//  mem_pc_i, mem_in_ds_i         MEM PC and delay-slot flag
//  mem_daddr_i                   load/store effective address
//  exc_flags_i, mem_eret_i       exception flags, eret in MEM
//  cp0_status_i/cause_i/epc_i    current CP0 values
//  wb_cp0_we_i/waddr_i/wdata_i   mtc0 in WB, bypassed into status/cause/EPC
//  excepttype_o, exc_pc_o,
//  exc_in_ds_o, bad_addr_o       one-cycle commit to CP0
//  flush_o                       flush all pipeline stages
//  redirect_valid_o/pc_o/ready_i fetch redirect handshake
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_i,
  input  logic        timer_int_i,
  output logic [5:0]  int_sync_o,
  input  logic        mem_valid_i,
  input  logic        mem_stall_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_ds_i,
  input  logic [31:0] mem_daddr_i,
  input  logic [7:0]  exc_flags_i,
  input  logic        mem_eret_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_wdata_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] exc_pc_o,
  output logic        exc_in_ds_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ready_i
);

  typedef enum logic [1:0] {IDLE, FLUSH, WAIT} state_t;

  localparam logic [4:0] CODE_NONE = 5'h00;
  localparam logic [4:0] CODE_INT  = 5'h01;
  localparam logic [4:0] CODE_ADEL = 5'h04;
  localparam logic [4:0] CODE_ADES = 5'h05;
  localparam logic [4:0] CODE_SYS  = 5'h08;
  localparam logic [4:0] CODE_BP   = 5'h09;
  localparam logic [4:0] CODE_RI   = 5'h0a;
  localparam logic [4:0] CODE_OV   = 5'h0c;
  localparam logic [4:0] CODE_TR   = 5'h0d;
  localparam logic [4:0] CODE_ERET = 5'h0e;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [5:0]  sync1, sync2;
  logic [31:0] status_eff, epc_eff;
  logic [1:0]  ip_sw;
  logic        int_pending;
  logic [4:0]  code;
  logic [31:0] bad_addr;
  logic        detect;
  logic [31:0] target;
  logic        unused_bits;

  // Two-flop synchroniser; runs in every state so CP0 always sees live lines.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= int_i;
      sync2 <= sync1;
    end
  end

  // Timer interrupt lands on IP7, i.e. bit 5 of the CP0 int_i bus.
  assign int_sync_o = sync2 | {timer_int_i, 5'b0};

  // An mtc0 in WB this cycle is not yet visible in CP0, so bypass it.
  assign status_eff = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) ? wb_cp0_wdata_i : cp0_status_i;
  assign ip_sw      = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) ? wb_cp0_wdata_i[9:8]
                                                               : cp0_cause_i[9:8];
  assign epc_eff    = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) ? wb_cp0_wdata_i : cp0_epc_i;

  // Hardware IP bits come straight from the synchroniser, not the CP0 copy.
  assign int_pending = status_eff[0] & ~status_eff[1]
                     & (|({int_sync_o, ip_sw} & status_eff[15:8]));

  assign unused_bits = ^{status_eff[31:16], status_eff[7:2],
                         cp0_cause_i[31:10], cp0_cause_i[7:0]};

  // Priority encoder; a zero code means nothing to report.
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    code     = CODE_NONE;
    bad_addr = '0;
    if (int_pending)         code = CODE_INT;
    else if (exc_flags_i[0]) begin
      code     = CODE_ADEL;
      bad_addr = mem_pc_i;
    end
    else if (exc_flags_i[1]) code = CODE_RI;
    else if (exc_flags_i[2]) code = CODE_OV;
    else if (exc_flags_i[3]) code = CODE_TR;
    else if (exc_flags_i[4]) code = CODE_SYS;
    else if (exc_flags_i[5]) code = CODE_BP;
    else if (exc_flags_i[6]) begin
      code     = CODE_ADEL;
      bad_addr = mem_daddr_i;
    end
    else if (exc_flags_i[7]) begin
      code     = CODE_ADES;
      bad_addr = mem_daddr_i;
    end
    else if (mem_eret_i)     code = CODE_ERET;
  end

  assign detect = (state == IDLE) && mem_valid_i && !mem_stall_i && (code != CODE_NONE);
  assign target = (code == CODE_ERET) ? epc_eff : EXC_VECTOR;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: if (detect) begin
        state_next = FLUSH;
        cnt_next   = 4'(FLUSH_CYCLES - 1);
      end
      FLUSH: begin
        if (cnt == 4'd0) state_next = WAIT;
        else             cnt_next   = cnt - 4'd1;
      end
      WAIT: if (redirect_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign flush_o          = (state == FLUSH);
  assign redirect_valid_o = (state == WAIT);

  // Commit outputs are a single-cycle pulse; the redirect target is held from
  // detect until the next detect so it stays stable through WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      excepttype_o  <= '0;
      exc_pc_o      <= '0;
      exc_in_ds_o   <= 1'b0;
      bad_addr_o    <= '0;
      redirect_pc_o <= '0;
    end else begin
      excepttype_o <= detect ? {27'b0, code} : '0;
      exc_pc_o     <= detect ? mem_pc_i : '0;
      exc_in_ds_o  <= detect & mem_in_ds_i;
      bad_addr_o   <= detect ? bad_addr : '0;
      if (detect) redirect_pc_o <= target;
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed self-checking bench for exc_ctrl.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  int_i;
  logic        timer_int_i;
  logic [5:0]  int_sync_o;
  logic        mem_valid_i, mem_stall_i, mem_in_ds_i, mem_eret_i;
  logic [31:0] mem_pc_i, mem_daddr_i;
  logic [7:0]  exc_flags_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_wdata_i;
  logic [31:0] excepttype_o, exc_pc_o, bad_addr_o, redirect_pc_o;
  logic        exc_in_ds_o, flush_o, redirect_valid_o, redirect_ready_i;

  int checks = 0;
  int errors = 0;

  exc_ctrl dut (
    .clk(clk), .rst(rst), .int_i(int_i), .timer_int_i(timer_int_i),
    .int_sync_o(int_sync_o), .mem_valid_i(mem_valid_i), .mem_stall_i(mem_stall_i),
    .mem_pc_i(mem_pc_i), .mem_in_ds_i(mem_in_ds_i), .mem_daddr_i(mem_daddr_i),
    .exc_flags_i(exc_flags_i), .mem_eret_i(mem_eret_i), .cp0_status_i(cp0_status_i),
    .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i), .wb_cp0_we_i(wb_cp0_we_i),
    .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_wdata_i(wb_cp0_wdata_i),
    .excepttype_o(excepttype_o), .exc_pc_o(exc_pc_o), .exc_in_ds_o(exc_in_ds_o),
    .bad_addr_o(bad_addr_o), .flush_o(flush_o), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o), .redirect_ready_i(redirect_ready_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    mem_valid_i    = 1'b0;
    mem_stall_i    = 1'b0;
    mem_in_ds_i    = 1'b0;
    mem_eret_i     = 1'b0;
    exc_flags_i    = '0;
    mem_pc_i       = '0;
    mem_daddr_i    = '0;
    wb_cp0_we_i    = 1'b0;
    wb_cp0_waddr_i = '0;
    wb_cp0_wdata_i = '0;
  endtask

  // Called in the commit cycle: two flush cycles, then WAIT with ready
  // already high so the handshake completes in one cycle.
  task automatic run_to_idle(input string tag, input logic [31:0] pc);
    check({tag, "_flush1"}, {31'b0, flush_o}, 32'd1);
    tick();
    check({tag, "_flush2"}, {31'b0, flush_o}, 32'd1);
    check({tag, "_pulse_gone"}, excepttype_o, 32'h0);
    tick();
    check({tag, "_flush_drop"}, {31'b0, flush_o}, 32'd0);
    check({tag, "_rvalid"}, {31'b0, redirect_valid_o}, 32'd1);
    check({tag, "_rpc"}, redirect_pc_o, pc);
    redirect_ready_i = 1'b1;
    tick();
    check({tag, "_rvalid_clr"}, {31'b0, redirect_valid_o}, 32'd0);
    redirect_ready_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    int_i = '0;
    timer_int_i = 1'b0;
    cp0_status_i = '0;
    cp0_cause_i = '0;
    cp0_epc_i = '0;
    redirect_ready_i = 1'b0;
    clear_mem();
    tick();
    tick();
    rst = 1'b0;
    check("rst_type", excepttype_o, 32'h0);
    check("rst_flush", {31'b0, flush_o}, 32'd0);
    check("rst_rvalid", {31'b0, redirect_valid_o}, 32'd0);
    check("rst_rpc", redirect_pc_o, 32'h0);
    check("rst_sync", {26'b0, int_sync_o}, 32'h0);

    // 1: hardware interrupt 0 (IP2, cause bit 10) enabled by status IM2 | IE.
    cp0_status_i = 32'h0000_0401;
    int_i = 6'b000001;
    tick();
    check("sync_lat1", {26'b0, int_sync_o}, 32'h0);
    tick();
    check("sync_lat2", {26'b0, int_sync_o}, 32'h1);
    timer_int_i = 1'b1;
    #1;
    check("sync_timer", {26'b0, int_sync_o}, 32'h21);
    timer_int_i = 1'b0;
    mem_valid_i = 1'b1;
    mem_pc_i = 32'hBFC0_0100;
    tick();
    check("int_type", excepttype_o, 32'h1);
    check("int_pc", exc_pc_o, 32'hBFC0_0100);
    check("int_ds", {31'b0, exc_in_ds_o}, 32'd0);
    check("int_bad", bad_addr_o, 32'h0);
    clear_mem();
    int_i = '0;
    cp0_status_i = '0;
    run_to_idle("int", 32'hBFC0_0380);

    // 2a: RI and Ov together -> RI wins.
    mem_valid_i = 1'b1;
    mem_pc_i = 32'h0000_0400;
    exc_flags_i = 8'b0000_0110;
    tick();
    check("ri_type", excepttype_o, 32'ha);
    check("ri_bad", bad_addr_o, 32'h0);
    clear_mem();
    run_to_idle("ri", 32'hBFC0_0380);

    // 2b: AdEL on load reports the data address.
    mem_valid_i = 1'b1;
    mem_pc_i = 32'h0000_0404;
    mem_daddr_i = 32'h8000_0003;
    exc_flags_i = 8'b0100_0000;
    tick();
    check("adel_ld_type", excepttype_o, 32'h4);
    check("adel_ld_bad", bad_addr_o, 32'h8000_0003);
    clear_mem();
    run_to_idle("adel_ld", 32'hBFC0_0380);

    // 2c: fetch AdEL beats AdES, reports the PC; delay-slot flag passes through.
    mem_valid_i = 1'b1;
    mem_in_ds_i = 1'b1;
    mem_pc_i = 32'h0000_0801;
    mem_daddr_i = 32'h0000_1234;
    exc_flags_i = 8'b1000_0001;
    tick();
    check("adel_if_type", excepttype_o, 32'h4);
    check("adel_if_bad", bad_addr_o, 32'h0000_0801);
    check("adel_if_ds", {31'b0, exc_in_ds_o}, 32'd1);
    clear_mem();
    run_to_idle("adel_if", 32'hBFC0_0380);

    // 3: eret with an mtc0 to EPC in WB the same cycle.
    cp0_epc_i = 32'h0000_1000;
    mem_valid_i = 1'b1;
    mem_pc_i = 32'h0000_0500;
    mem_eret_i = 1'b1;
    wb_cp0_we_i = 1'b1;
    wb_cp0_waddr_i = 5'd14;
    wb_cp0_wdata_i = 32'h0000_2000;
    tick();
    check("eret_type", excepttype_o, 32'he);
    clear_mem();
    run_to_idle("eret", 32'h0000_2000);

    // 4: ready held low in WAIT; a second exception meanwhile is ignored.
    mem_valid_i = 1'b1;
    mem_pc_i = 32'h0000_0600;
    exc_flags_i = 8'b0001_0000;
    tick();
    check("sys_type", excepttype_o, 32'h8);
    clear_mem();
    tick();
    tick();
    mem_valid_i = 1'b1;
    exc_flags_i = 8'b0010_0000;
    for (int i = 0; i < 5; i++) begin
      check("wait_rvalid", {31'b0, redirect_valid_o}, 32'd1);
      check("wait_rpc", redirect_pc_o, 32'hBFC0_0380);
      check("wait_no_type", excepttype_o, 32'h0);
      tick();
    end
    check("wait_rvalid5", {31'b0, redirect_valid_o}, 32'd1);
    clear_mem();
    redirect_ready_i = 1'b1;
    tick();
    redirect_ready_i = 1'b0;
    check("wait_done", {31'b0, redirect_valid_o}, 32'd0);
    check("wait_no_flush", {31'b0, flush_o}, 32'd0);
    check("wait_no_redetect", excepttype_o, 32'h0);

    // 5: stall held 3 cycles over an Ov.
    mem_valid_i = 1'b1;
    mem_stall_i = 1'b1;
    mem_pc_i = 32'h0000_0700;
    exc_flags_i = 8'b0000_0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_no_type", excepttype_o, 32'h0);
      check("stall_no_flush", {31'b0, flush_o}, 32'd0);
    end
    mem_stall_i = 1'b0;
    tick();
    check("ov_type", excepttype_o, 32'hc);
    check("ov_pc", exc_pc_o, 32'h0000_0700);
    clear_mem();
    run_to_idle("ov", 32'hBFC0_0380);

    // 6: reset during the first flush cycle, then a normal exception.
    mem_valid_i = 1'b1;
    mem_pc_i = 32'h0000_0900;
    exc_flags_i = 8'b0000_1000;
    tick();
    check("trap_type", excepttype_o, 32'hd);
    check("trap_flush", {31'b0, flush_o}, 32'd1);
    clear_mem();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("r6_type", excepttype_o, 32'h0);
    check("r6_pc", exc_pc_o, 32'h0);
    check("r6_bad", bad_addr_o, 32'h0);
    check("r6_flush", {31'b0, flush_o}, 32'd0);
    check("r6_rvalid", {31'b0, redirect_valid_o}, 32'd0);
    check("r6_rpc", redirect_pc_o, 32'h0);
    mem_valid_i = 1'b1;
    mem_pc_i = 32'h0000_0A00;
    exc_flags_i = 8'b0010_0000;
    tick();
    check("bp_type", excepttype_o, 32'h9);
    check("bp_pc", exc_pc_o, 32'h0000_0A00);
    clear_mem();
    run_to_idle("bp", 32'hBFC0_0380);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
